// File: rtl/ahb_mtx_arb_rr.sv
// ahb_mtx_arb_rr
// Round-robin output-stage arbiter for one AHB bus-matrix slave port.
// Selects one of NUM_PORTS input ports (addr_in_port) or none (no_port).
// The current owner keeps the grant while HMASTLOCKM is high. When the
// AHB_ARB_BURST_HOLD_EN macro is defined, it also keeps the grant for the
// full length of fixed-length bursts (INCR4/8/16, WRAP4/8/16).
//
// Handshake: every register advances only on a rising HCLK edge with
// HREADYM=1. When HREADYM=0 the whole arbiter holds its state, so a
// stalled transfer never sees its grant move.

module ahb_mtx_arb_rr #(
    parameter int NUM_PORTS = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [2:0]           addr_in_port,
    output logic                 no_port
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    // Grant register. r_addr keeps the last granted port even while
    // r_no_port is set, so the next search resumes after that port.
    logic [2:0]           r_addr;
    logic                 r_no_port;

    logic [NUM_PORTS-1:0] w_eff_req;
    logic [3:0]           w_cnt_next;
    logic                 w_hit;
    logic [2:0]           w_rr_addr;
    logic [2:0]           w_addr_next;
    logic                 w_no_port_next;

    // Effective request: the current owner still counts as a requester
    // while its own address phase is active (selected and not IDLE).
    always_comb begin
        w_eff_req = req_port;
        for (int n = 0; n < NUM_PORTS; n++) begin
            if ((r_addr == 3'(n)) && !r_no_port && HSELM &&
                (HTRANSM != TRANS_IDLE)) begin
                w_eff_req[n] = 1'b1;
            end
        end
    end

`ifdef AHB_ARB_BURST_HOLD_EN
    // Remaining beats of the current fixed-length burst.
    logic [3:0] r_cnt;

    // Beat counter next value: load on a selected NONSEQ, count down on
    // SEQ, freeze on BUSY, clear on IDLE (early burst termination).
    always_comb begin
        w_cnt_next = r_cnt;
        case (HTRANSM)
            TRANS_NONSEQ: begin
                if (HSELM) begin
                    case (HBURSTM)
                        BURST_INCR4,  BURST_WRAP4:  w_cnt_next = 4'd3;
                        BURST_INCR8,  BURST_WRAP8:  w_cnt_next = 4'd7;
                        BURST_INCR16, BURST_WRAP16: w_cnt_next = 4'd15;
                        default:                    w_cnt_next = 4'd0;
                    endcase
                end else begin
                    w_cnt_next = 4'd0;
                end
            end
            TRANS_SEQ: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            TRANS_BUSY: w_cnt_next = r_cnt;
            default:    w_cnt_next = 4'd0;
        endcase
    end

    // Beat counter register; advances only on accepted beats.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= 4'd0;
        end else if (HREADYM) begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    // Without burst hold the arbiter may re-arbitrate on every beat.
    logic w_unused_burst;

    // No beat counter in this build: burst hold never applies.
    always_comb begin
        w_cnt_next     = 4'd0;
        w_unused_burst = ^HBURSTM;
    end
`endif

    // Round-robin search: start just after the last granted port and
    // wrap around so the last granted port itself is tried last.
    always_comb begin
        w_hit     = 1'b0;
        w_rr_addr = r_addr;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!w_hit && w_eff_req[(int'(r_addr) + i) % NUM_PORTS]) begin
                w_hit     = 1'b1;
                w_rr_addr = 3'((int'(r_addr) + i) % NUM_PORTS);
            end
        end
    end

    // Next-grant priority: lock, then burst hold, then round-robin, then
    // park on the current port while the slave is still selected.
    always_comb begin
        w_addr_next    = r_addr;
        w_no_port_next = r_no_port;
        if (HMASTLOCKM) begin
            w_addr_next    = r_addr;
            w_no_port_next = r_no_port;
        end else if (w_cnt_next != 4'd0) begin
            w_addr_next    = r_addr;
            w_no_port_next = r_no_port;
        end else if (w_hit) begin
            w_addr_next    = w_rr_addr;
            w_no_port_next = 1'b0;
        end else if (HSELM) begin
            w_no_port_next = 1'b0;
        end else begin
            w_no_port_next = 1'b1;
        end
    end

    // Grant register; cleared asynchronously, advances on accepted beats.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr    <= 3'd0;
            r_no_port <= 1'b1;
        end else if (HREADYM) begin
            r_addr    <= w_addr_next;
            r_no_port <= w_no_port_next;
        end
    end

    assign addr_in_port = r_addr;
    assign no_port      = r_no_port;

endmodule

// File: tb/tb_ahb_mtx_arb_rr.sv
// Bench for ahb_mtx_arb_rr with NUM_PORTS=4. Expected grants are written
// by hand for each stimulus beat and go through an expected queue.
// Where burst hold changes the outcome, the expectation follows the
// AHB_ARB_BURST_HOLD_EN build in use.

module tb_ahb_mtx_arb_rr;

    localparam int NP = 4;
`ifdef AHB_ARB_BURST_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [NP-1:0] req_port = '0;
    logic          HREADYM = 1'b1;
    logic          HSELM = 1'b0;
    logic [1:0]    HTRANSM = IDLE;
    logic [2:0]    HBURSTM = SINGLE;
    logic          HMASTLOCKM = 1'b0;
    logic [2:0]    addr_in_port;
    logic          no_port;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] exp_q[$];

    ahb_mtx_arb_rr #(.NUM_PORTS(NP)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port),
        .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_in_port), .no_port(no_port)
    );

    // Clock
    always #5 HCLK = ~HCLK;

    // Checker: observed vs expected, value shown as {no_port, addr}
    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply one beat, queue the grant expected after the edge,
    // then compare the DUT output against the queue head.
    task automatic drive_beat(input string tag, input logic [NP-1:0] req, input logic rdy,
                              input logic sel, input logic [1:0] tr, input logic [2:0] bu,
                              input logic lk, input logic exp_np, input logic [2:0] exp_addr);
        logic [3:0] e;
        req_port   = req;
        HREADYM    = rdy;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
        exp_q.push_back({exp_np, exp_addr});
        @(posedge HCLK);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {4'd0, no_port, addr_in_port}, {4'd0, e});
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("reset", {4'd0, no_port, addr_in_port}, 8'h08);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Idle after reset: nothing changes
        drive_beat("idle0", 4'b0000, 1, 0, IDLE, SINGLE, 0, 1, 3'd0);
        drive_beat("idle1", 4'b0000, 1, 0, IDLE, SINGLE, 0, 1, 3'd0);

        // Rotation with all ports requesting
        drive_beat("rot1", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd1);
        drive_beat("rot2", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);
        drive_beat("rot3", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd3);
        drive_beat("rot0", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd0);
        drive_beat("rot1b", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd1);

        // Wait states with changing requests: grant frozen
        for (int i = 0; i < 3; i++) begin
            drive_beat("wait", 4'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)),
                       NSEQ, SINGLE, 1'($urandom_range(0, 1)), 0, 3'd1);
        end
        drive_beat("wait_rel", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);

        // No request: park while selected, drop when deselected
        drive_beat("park", 4'b0000, 1, 1, IDLE, SINGLE, 0, 0, 3'd2);
        drive_beat("noport", 4'b0000, 1, 0, IDLE, SINGLE, 0, 1, 3'd2);
        drive_beat("resume", 4'b1001, 1, 0, IDLE, SINGLE, 0, 0, 3'd3);
        drive_beat("to2a", 4'b0100, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);

        // INCR4 burst on port 2 while 0, 1, 3 request
        drive_beat("b4_nseq", 4'b1011, 1, 1, NSEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd3);
        drive_beat("b4_seq1", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd0);
        drive_beat("b4_seq2", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd1);
        drive_beat("b4_seq3", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, 3'd3);
        drive_beat("to2b", 4'b0100, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);

        // Same burst with a BUSY beat inserted
        drive_beat("bb_nseq", 4'b1011, 1, 1, NSEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd3);
        drive_beat("bb_seq1", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd0);
        drive_beat("bb_busy", 4'b1011, 1, 1, BUSY, INCR4, 0, 0, HOLD ? 3'd2 : 3'd1);
        drive_beat("bb_seq2", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd3);
        drive_beat("bb_seq3", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd3 : 3'd0);
        drive_beat("to2c", 4'b0100, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);

        // Same burst terminated early by IDLE
        drive_beat("bi_nseq", 4'b1011, 1, 1, NSEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd3);
        drive_beat("bi_seq1", 4'b1011, 1, 1, SEQ, INCR4, 0, 0, HOLD ? 3'd2 : 3'd0);
        drive_beat("bi_idle", 4'b1011, 1, 1, IDLE, INCR4, 0, 0, HOLD ? 3'd3 : 3'd1);

        // Lock on port 0 with ports 1..3 requesting
        drive_beat("to0", 4'b0001, 1, 1, NSEQ, SINGLE, 0, 0, 3'd0);
        drive_beat("lk1", 4'b1110, 1, 1, NSEQ, SINGLE, 1, 0, 3'd0);
        drive_beat("lk2", 4'b1110, 1, 1, NSEQ, SINGLE, 1, 0, 3'd0);
        drive_beat("lk3", 4'b1110, 1, 1, NSEQ, INCR4, 1, 0, 3'd0);
        drive_beat("lk4", 4'b1110, 1, 1, SEQ, INCR4, 1, 0, 3'd0);
        drive_beat("lk5", 4'b1110, 1, 1, SEQ, INCR4, 1, 0, 3'd0);
        drive_beat("lk_drop", 4'b1110, 1, 1, SEQ, INCR4, 0, 0, 3'd1);

        // Reset asserted mid-burst
        drive_beat("rb_nseq", 4'b1111, 1, 1, NSEQ, INCR4, 0, 0, HOLD ? 3'd1 : 3'd2);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("rst_async", {4'd0, no_port, addr_in_port}, 8'h08);
        HTRANSM = NSEQ;
        HBURSTM = SINGLE;
        @(posedge HCLK);
        #1;
        check_eq("rst_hold", {4'd0, no_port, addr_in_port}, 8'h08);
        HRESETn = 1'b1;
        drive_beat("post_rst1", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd1);
        drive_beat("post_rst2", 4'b1111, 1, 1, NSEQ, SINGLE, 0, 0, 3'd2);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // Report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
